// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word-organised SRAM, byte/word access, fixed response latency.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned word accesses are neutralised and flagged on sticky misalign_o.
module dmem_responder #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        valid_i,
  input  logic        wen_i,
  input  logic        byte_not_word_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        yumi_i,
  output logic        yumi_o,
  output logic        valid_o,
  output logic [31:0] read_data_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int Words = 2 ** addr_width_p;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              count_q, count_d;
  logic [31:0]             respData_q, respData_d;
  logic [31:0]             mem [Words];
  logic                    accept;
  logic                    misalign;
  logic [addr_width_p-1:0] wordIdx;
  logic [1:0]              lane;
  logic [31:0]             loadWord;
  logic [31:0]             loadData;
  logic                    unusedAddrBits;

  // Upper address bits alias onto the array, so they are deliberately dropped.
  assign wordIdx        = addr_i[addr_width_p+1:2];
  assign lane           = addr_i[1:0];
  assign unusedAddrBits = ^addr_i[31:addr_width_p+2];

  assign accept = valid_i && (state_q == IDLE) && n_reset;
  assign yumi_o = accept;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = !byte_not_word_i && (lane != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign loadWord = mem[wordIdx];

  always_comb begin
    loadData = loadWord;
    if (misalign) begin
      loadData = 32'h0;
    end else if (byte_not_word_i) begin
      loadData = {24'h0, loadWord[{lane, 3'b000} +: 8]};
    end
  end

  // Stores commit at the accept edge; the array has no reset.
  always_ff @(posedge clk) begin
    if (accept && wen_i && !misalign) begin
      if (byte_not_word_i) begin
        mem[wordIdx][{lane, 3'b000} +: 8] <= write_data_i[7:0];
      end else begin
        mem[wordIdx] <= write_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      respData_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      respData_q <= respData_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    respData_d = respData_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          respData_d = wen_i ? 32'h0 : loadData;
          count_d    = 4'(latency_p - 1);
          state_d    = (latency_p == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (yumi_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign valid_o     = (state_q == RESP);
  assign read_data_o = respData_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      misalign_q <= 1'b0;
    end else if (accept && misalign) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_o = misalign_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves the core's load/store request interface: request valid/yumi in, response valid/yumi out.
- Holds a word-organised SRAM array and accepts one request at a time.
- Performs the byte or word access and returns a response after a fixed, parameterised latency.
- Sits between each core's data-memory port and on-chip data storage.

Parameters:
- addr_width_p, 10: word-address width; the array holds 2**addr_width_p 32-bit words.
- latency_p, 2: cycles from request accept to response valid. Legal range is 1..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- valid_i  input  1  request valid from the core; held high until yumi_o.
- wen_i  input  1  1 = store, 0 = load.
- byte_not_word_i  input  1  1 = byte access, 0 = word access.
- addr_i  input  32  byte address.
- write_data_i  input  32  store data; a byte store uses bits [7:0].
- yumi_i  input  1  core acknowledges the response.
- yumi_o  output  1  request accepted this cycle.
- valid_o  output  1  response valid; held until yumi_i.
- read_data_o  output  32  load result; 0 for stores.

Behaviour:
- Addressing:
  - word index = addr_i[addr_width_p+1:2]; byte lane = addr_i[1:0], lane 0 = bits [7:0].
  - addr_i bits above addr_width_p+1 are ignored, so addresses wrap modulo the array size.
- States:
  - IDLE: no request in flight.
  - WAIT: counting latency.
  - RESP: valid_o high, waiting for yumi_i.
- Accept:
  - yumi_o = valid_i && state==IDLE; combinational, same cycle as valid_i.
  - Forced to 0 while n_reset is low.
  - Requests in WAIT or RESP are not accepted; valid_i is held by the core.
- At the accept edge:
  - Store: word store writes all 4 lanes. Byte store writes only the addressed lane with write_data_i[7:0]; the other 3 lanes are unchanged.
  - Load: the addressed word is captured. A byte load returns the lane zero-extended to 32 bits. The captured value goes into the response register.
  - Store response data is 0.
- Latency counter:
  - Loaded with latency_p-1 on accept; decrements each cycle in WAIT.
  - If latency_p==1: IDLE -> RESP directly on accept.
  - Otherwise: IDLE -> WAIT, and WAIT -> RESP when the counter reaches 0.
  - valid_o first rises exactly latency_p cycles after the accept cycle.
- RESP:
  - valid_o=1 and read_data_o stable until yumi_i is sampled high; then state becomes IDLE at that edge.
  - valid_o=0 next cycle.
  - A new request can be accepted no earlier than the cycle after yumi_i. Maximum throughput is one request per latency_p+1 cycles.
- yumi_i outside RESP is ignored.
- Load-after-store to the same address returns the stored data, because writes commit at accept.
- Reset (asynchronous, including mid-operation):
  - state=IDLE, counter=0, valid_o=0, read_data_o=0.
  - Any in-flight request is dropped with no response.
  - A store already written at its accept edge stays written.
  - Array contents are not reset.
- Every load response is registered; there is no combinational path from addr_i to read_data_o.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- When defined:
  - A word access with addr_i[1:0]!=0 is still accepted and responded to with normal latency.
  - The store is suppressed and the load returns 32'h0.
  - A sticky output misalign_o (1 bit, reset 0) is set; it clears only on reset.
- When undefined:
  - addr_i[1:0] is ignored for word accesses.
  - The misalign_o port is absent.

Test Plan:
- latency_p=2; word store addr 0x10 data 0xDEADBEEF -> yumi_o same cycle, valid_o 2 cycles later with read_data_o=0. Then a word load at 0x10 -> read_data_o=0xDEADBEEF.
- Byte store 0xAA to addr 0x13, then a word load at 0x10 -> 0xAAADBEEF. Byte load at 0x11 -> 0x000000BE.
- Response held: hold yumi_i=0 for 5 cycles after valid_o -> valid_o and read_data_o stable. Assert yumi_i -> valid_o=0 next cycle. A back-to-back valid_i gets yumi_o no earlier than that cycle.
- New request while in WAIT -> yumi_o=0 until IDLE. Address 0x1010 with addr_width_p=10 -> aliases word 4 (0x10).
- Assert n_reset=0 mid-WAIT -> valid_o=0 immediately. After release, no stale response; a fresh load works. latency_p=1 -> valid_o in the cycle after accept.
- With DMEM_ALIGN_CHECK_EN: word store to 0x12 -> memory unchanged, load returns 0, misalign_o=1 and stays 1.
